// File: rtl/pr_busy_table_pkg.sv
// Shared core sizing for the register file, rename and the PR busy table.
// Also holds the writeback port ordering used to pack the per-port buses.
package pr_busy_table_pkg;

    localparam int CORE_NUM_PR    = 64;
    localparam int CORE_PR_W      = 6;
    localparam int CORE_NUM_WB    = 4;
    localparam int CORE_NUM_ALLOC = 2;
    localparam int CORE_NUM_SRC   = 4;

    // Bit position of each writeback port inside the packed wb buses.
    typedef enum logic [1:0] {
        WB_ALU0 = 2'd0,
        WB_ALU1 = 2'd1,
        WB_AGU  = 2'd2,
        WB_BRU  = 2'd3
    } wb_port_e;

endpackage

// File: rtl/pr_busy_table_wb_match.sv
// Bypass comparator: flags a source PR that is being written back this cycle.
// The PR0 case is left to the caller, which forces PR0 ready anyway.
module pr_wb_match
    import pr_busy_table_pkg::*;
#(
    parameter int PR_W = CORE_PR_W
) (
    input  logic [PR_W-1:0]                  query_pr_i,
    input  logic [CORE_NUM_WB-1:0]           wb_vld_i,
    input  logic [CORE_NUM_WB-1:0][PR_W-1:0] wb_pr_i,
    output logic                             match_o
);

    logic [CORE_NUM_WB-1:0] hit;

    generate
        for (genvar gi = 0; gi < CORE_NUM_WB; gi++) begin : g_cmp
            assign hit[gi] = wb_vld_i[gi] && (wb_pr_i[gi] == query_pr_i);
        end
    endgenerate

    assign match_o = |hit;

endmodule

// File: rtl/pr_busy_table.sv
// Physical-register ready/busy scoreboard: allocation clears, writeback sets,
// flush/reset mark everything ready; source queries see same-cycle writebacks.
module pr_busy_table
    import pr_busy_table_pkg::*;
#(
    parameter int NUM_PR = CORE_NUM_PR,
    parameter int PR_W   = CORE_PR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alloc0_vld,
    input  logic [PR_W-1:0]   alloc0_PR,
    input  logic              alloc1_vld,
    input  logic [PR_W-1:0]   alloc1_PR,
    input  logic              ALU0_result_vld,
    input  logic [PR_W-1:0]   ALU0_result_PR,
    input  logic              ALU1_result_vld,
    input  logic [PR_W-1:0]   ALU1_result_PR,
    input  logic              AGU_result_vld,
    input  logic [PR_W-1:0]   AGU_result_PR,
    input  logic              BRU_result_vld,
    input  logic [PR_W-1:0]   BRU_result_PR,
    input  logic              flush,
    input  logic [PR_W-1:0]   src0_PR,
    input  logic [PR_W-1:0]   src1_PR,
    input  logic [PR_W-1:0]   src2_PR,
    input  logic [PR_W-1:0]   src3_PR,
    output logic              src0_rdy,
    output logic              src1_rdy,
    output logic              src2_rdy,
    output logic              src3_rdy,
    output logic [NUM_PR-1:0] ready_vec,
    output logic [PR_W:0]     busy_cnt
);

    logic [CORE_NUM_WB-1:0]              wb_vld;
    logic [CORE_NUM_WB-1:0][PR_W-1:0]    wb_pr;
    logic [CORE_NUM_ALLOC-1:0]           alloc_vld;
    logic [CORE_NUM_ALLOC-1:0][PR_W-1:0] alloc_pr;
    logic [CORE_NUM_SRC-1:0][PR_W-1:0]   src_pr;
    logic [CORE_NUM_SRC-1:0]             src_rdy;

    logic [NUM_PR-1:0] ready_q, ready_d;
    logic [PR_W:0]     busy_cnt_q, busy_cnt_d;

    always_comb begin
        wb_vld          = '0;
        wb_pr           = '0;
        wb_vld[WB_ALU0] = ALU0_result_vld;
        wb_pr[WB_ALU0]  = ALU0_result_PR;
        wb_vld[WB_ALU1] = ALU1_result_vld;
        wb_pr[WB_ALU1]  = ALU1_result_PR;
        wb_vld[WB_AGU]  = AGU_result_vld;
        wb_pr[WB_AGU]   = AGU_result_PR;
        wb_vld[WB_BRU]  = BRU_result_vld;
        wb_pr[WB_BRU]   = BRU_result_PR;
    end

    assign alloc_vld = {alloc1_vld, alloc0_vld};
    assign alloc_pr  = {alloc1_PR, alloc0_PR};
    assign src_pr    = {src3_PR, src2_PR, src1_PR, src0_PR};

    // Writebacks first, allocations second so an allocation wins on a tie;
    // flush overrides both.
    always_comb begin
        ready_d = ready_q;
        for (int i = 0; i < CORE_NUM_WB; i++) begin
            if (wb_vld[i] && (wb_pr[i] != '0)) begin
                ready_d[wb_pr[i]] = 1'b1;
            end
        end
        for (int i = 0; i < CORE_NUM_ALLOC; i++) begin
            if (alloc_vld[i] && (alloc_pr[i] != '0)) begin
                ready_d[alloc_pr[i]] = 1'b0;
            end
        end
        ready_d[0] = 1'b1;
        if (flush) begin
            ready_d = '1;
        end
    end

    // Popcount of the next-state vector keeps busy_cnt exact even with
    // duplicate writebacks or duplicate allocations in one cycle.
    always_comb begin
        busy_cnt_d = '0;
        for (int i = 0; i < NUM_PR; i++) begin
            busy_cnt_d = busy_cnt_d + {{PR_W{1'b0}}, ~ready_d[i]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ready_q    <= '1;
            busy_cnt_q <= '0;
        end else begin
            ready_q    <= ready_d;
            busy_cnt_q <= busy_cnt_d;
        end
    end

    generate
        for (genvar gi = 0; gi < CORE_NUM_SRC; gi++) begin : g_src
            logic bypass;

            pr_wb_match #(
                .PR_W(PR_W)
            ) u_match (
                .query_pr_i (src_pr[gi]),
                .wb_vld_i   (wb_vld),
                .wb_pr_i    (wb_pr),
                .match_o    (bypass)
            );

            // Same-cycle allocations are deliberately not visible here.
            assign src_rdy[gi] = (src_pr[gi] == '0) | ready_q[src_pr[gi]] | bypass;
        end
    endgenerate

    assign src0_rdy  = src_rdy[0];
    assign src1_rdy  = src_rdy[1];
    assign src2_rdy  = src_rdy[2];
    assign src3_rdy  = src_rdy[3];
    assign ready_vec = ready_q;
    assign busy_cnt  = busy_cnt_q;

endmodule

// File: tb/tb_pr_busy_table.sv
// Directed scoreboard bench for pr_busy_table: each step queues its expected
// source-ready bits (same cycle) and ready_vec/busy_cnt (after the next edge).
module tb_pr_busy_table;

    logic        clk = 1'b0;
    logic        rst;
    logic        alloc0_vld, alloc1_vld;
    logic [5:0]  alloc0_PR, alloc1_PR;
    logic        ALU0_result_vld, ALU1_result_vld, AGU_result_vld, BRU_result_vld;
    logic [5:0]  ALU0_result_PR, ALU1_result_PR, AGU_result_PR, BRU_result_PR;
    logic        flush;
    logic [5:0]  src0_PR, src1_PR, src2_PR, src3_PR;
    logic        src0_rdy, src1_rdy, src2_rdy, src3_rdy;
    logic [63:0] ready_vec;
    logic [6:0]  busy_cnt;

    pr_busy_table #(
        .NUM_PR(64),
        .PR_W(6)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .alloc0_vld      (alloc0_vld),
        .alloc0_PR       (alloc0_PR),
        .alloc1_vld      (alloc1_vld),
        .alloc1_PR       (alloc1_PR),
        .ALU0_result_vld (ALU0_result_vld),
        .ALU0_result_PR  (ALU0_result_PR),
        .ALU1_result_vld (ALU1_result_vld),
        .ALU1_result_PR  (ALU1_result_PR),
        .AGU_result_vld  (AGU_result_vld),
        .AGU_result_PR   (AGU_result_PR),
        .BRU_result_vld  (BRU_result_vld),
        .BRU_result_PR   (BRU_result_PR),
        .flush           (flush),
        .src0_PR         (src0_PR),
        .src1_PR         (src1_PR),
        .src2_PR         (src2_PR),
        .src3_PR         (src3_PR),
        .src0_rdy        (src0_rdy),
        .src1_rdy        (src1_rdy),
        .src2_rdy        (src2_rdy),
        .src3_rdy        (src3_rdy),
        .ready_vec       (ready_vec),
        .busy_cnt        (busy_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          due;
        bit          is_src;
        logic [3:0]  src;
        logic [63:0] vec;
        logic [6:0]  cnt;
        int          step;
    } exp_t;

    exp_t        sbq[$];
    int          errors = 0;
    int          checks = 0;
    int          step   = 0;
    logic [63:0] ev;

    task automatic clr();
        rst = 1'b0; flush = 1'b0;
        alloc0_vld = 1'b0; alloc0_PR = '0; alloc1_vld = 1'b0; alloc1_PR = '0;
        ALU0_result_vld = 1'b0; ALU0_result_PR = '0;
        ALU1_result_vld = 1'b0; ALU1_result_PR = '0;
        AGU_result_vld  = 1'b0; AGU_result_PR  = '0;
        BRU_result_vld  = 1'b0; BRU_result_PR  = '0;
        src0_PR = '0; src1_PR = '0; src2_PR = '0; src3_PR = '0;
    endtask

    task automatic srcs(input logic [5:0] a, input logic [5:0] b,
                        input logic [5:0] c, input logic [5:0] d);
        src0_PR = a; src1_PR = b; src2_PR = c; src3_PR = d;
    endtask

    // src_exp is {src3,src2,src1,src0}; ev must already hold the post-edge vector.
    task automatic commit(input logic [3:0] src_exp, input logic [6:0] cnt_exp);
        exp_t e;
        e.due = cyc; e.is_src = 1'b1; e.src = src_exp; e.vec = '0; e.cnt = '0; e.step = step;
        sbq.push_back(e);
        e.due = cyc + 1; e.is_src = 1'b0; e.src = '0; e.vec = ev; e.cnt = cnt_exp;
        sbq.push_back(e);
        step++;
        @(posedge clk);
        #1;
        clr();
    endtask

    initial begin
        forever begin
            @(negedge clk);
            while (sbq.size() > 0 && sbq[0].due <= cyc) begin
                exp_t e;
                e = sbq.pop_front();
                if (e.is_src) begin
                    checks++;
                    if ({src3_rdy, src2_rdy, src1_rdy, src0_rdy} !== e.src) begin
                        errors++;
                        $display("FAIL step%0d src_rdy: got %b expected %b", e.step,
                                 {src3_rdy, src2_rdy, src1_rdy, src0_rdy}, e.src);
                    end
                end else begin
                    checks += 2;
                    if (ready_vec !== e.vec) begin
                        errors++;
                        $display("FAIL step%0d ready_vec: got %h expected %h", e.step, ready_vec, e.vec);
                    end
                    if (busy_cnt !== e.cnt) begin
                        errors++;
                        $display("FAIL step%0d busy_cnt: got %0d expected %0d", e.step, busy_cnt, e.cnt);
                    end
                    $display("step %0d: ready_vec=%h busy_cnt=%0d", e.step, ready_vec, busy_cnt);
                end
            end
        end
    end

    initial begin
        clr();
        rst = 1'b1;
        ev  = '1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // S0: reset state, sources ready in the first cycle after reset
        srcs(0, 1, 2, 3);
        commit(4'b1111, 7'd0);
        // S1: alloc PR5 and PR9; allocs not visible to same-cycle queries
        alloc0_vld = 1; alloc0_PR = 5; alloc1_vld = 1; alloc1_PR = 9;
        srcs(5, 9, 0, 1);
        ev[5] = 1'b0; ev[9] = 1'b0;
        commit(4'b1111, 7'd2);
        // S2: idle, busy PRs read as not ready
        srcs(5, 9, 0, 6);
        commit(4'b1100, 7'd2);
        // S3: ALU1 writeback PR5 bypasses to src1/src2
        ALU1_result_vld = 1; ALU1_result_PR = 5;
        srcs(9, 5, 5, 9);
        ev[5] = 1'b1;
        commit(4'b0110, 7'd1);
        // S4: alloc PR12 and AGU writeback PR12 together, alloc wins
        alloc0_vld = 1; alloc0_PR = 12; AGU_result_vld = 1; AGU_result_PR = 12;
        srcs(12, 9, 5, 0);
        ev[12] = 1'b0;
        commit(4'b1101, 7'd2);
        // S5: alloc and writeback to PR0 are ignored
        alloc0_vld = 1; alloc0_PR = 0; alloc1_vld = 1; alloc1_PR = 0;
        ALU0_result_vld = 1; ALU0_result_PR = 0;
        srcs(0, 12, 9, 3);
        commit(4'b1001, 7'd2);
        // S6: both slots allocate PR20
        alloc0_vld = 1; alloc0_PR = 20; alloc1_vld = 1; alloc1_PR = 20;
        srcs(20, 9, 12, 7);
        ev[20] = 1'b0;
        commit(4'b1001, 7'd3);
        // S7: alloc PR3/PR4, ALU0 writeback PR9
        alloc0_vld = 1; alloc0_PR = 3; alloc1_vld = 1; alloc1_PR = 4;
        ALU0_result_vld = 1; ALU0_result_PR = 9;
        srcs(9, 3, 12, 20);
        ev[9] = 1'b1; ev[3] = 1'b0; ev[4] = 1'b0;
        commit(4'b0011, 7'd4);
        // S8: alloc PR7/PR8 -> six busy
        alloc0_vld = 1; alloc0_PR = 7; alloc1_vld = 1; alloc1_PR = 8;
        srcs(7, 8, 3, 4);
        ev[7] = 1'b0; ev[8] = 1'b0;
        commit(4'b0011, 7'd6);
        // S9: four distinct writebacks 3,4,7,8
        ALU0_result_vld = 1; ALU0_result_PR = 3; ALU1_result_vld = 1; ALU1_result_PR = 4;
        AGU_result_vld  = 1; AGU_result_PR  = 7; BRU_result_vld  = 1; BRU_result_PR  = 8;
        srcs(3, 4, 7, 8);
        ev[3] = 1'b1; ev[4] = 1'b1; ev[7] = 1'b1; ev[8] = 1'b1;
        commit(4'b1111, 7'd2);
        // S10: make PR3 busy again
        alloc0_vld = 1; alloc0_PR = 3;
        srcs(3, 12, 20, 0);
        ev[3] = 1'b0;
        commit(4'b1001, 7'd3);
        // S11: all four writebacks target PR3 -> single decrement
        ALU0_result_vld = 1; ALU0_result_PR = 3; ALU1_result_vld = 1; ALU1_result_PR = 3;
        AGU_result_vld  = 1; AGU_result_PR  = 3; BRU_result_vld  = 1; BRU_result_PR  = 3;
        srcs(3, 3, 12, 20);
        ev[3] = 1'b1;
        commit(4'b0011, 7'd2);
        // S12: writeback PR with vld low must not bypass nor set
        ALU0_result_vld = 0; ALU0_result_PR = 12;
        alloc0_vld = 1; alloc0_PR = 30; alloc1_vld = 1; alloc1_PR = 31;
        srcs(12, 20, 30, 31);
        ev[30] = 1'b0; ev[31] = 1'b0;
        commit(4'b1100, 7'd4);
        // S13..S15: grow to ten busy PRs
        alloc0_vld = 1; alloc0_PR = 40; alloc1_vld = 1; alloc1_PR = 41;
        srcs(40, 41, 12, 63);
        ev[40] = 1'b0; ev[41] = 1'b0;
        commit(4'b1011, 7'd6);
        alloc0_vld = 1; alloc0_PR = 50; alloc1_vld = 1; alloc1_PR = 51;
        srcs(50, 51, 40, 41);
        ev[50] = 1'b0; ev[51] = 1'b0;
        commit(4'b0011, 7'd8);
        alloc0_vld = 1; alloc0_PR = 60; alloc1_vld = 1; alloc1_PR = 63;
        srcs(60, 63, 50, 51);
        ev[60] = 1'b0; ev[63] = 1'b0;
        commit(4'b0011, 7'd10);
        // S16: flush overrides same-cycle alloc PR20 and writeback PR12
        flush = 1; alloc0_vld = 1; alloc0_PR = 20; ALU0_result_vld = 1; ALU0_result_PR = 12;
        srcs(12, 20, 60, 63);
        ev = '1;
        commit(4'b0001, 7'd0);
        // S17: alloc PR1/PR2 after flush
        alloc0_vld = 1; alloc0_PR = 1; alloc1_vld = 1; alloc1_PR = 2;
        srcs(60, 63, 1, 2);
        ev[1] = 1'b0; ev[2] = 1'b0;
        commit(4'b1111, 7'd2);
        // S18: reset overrides alloc and writeback
        rst = 1; alloc0_vld = 1; alloc0_PR = 5; ALU0_result_vld = 1; ALU0_result_PR = 1;
        srcs(1, 2, 5, 0);
        ev = '1;
        commit(4'b1101, 7'd0);
        // S19: sources read from reset state
        srcs(1, 2, 5, 0);
        commit(4'b1111, 7'd0);
        // S20: alloc PR10/PR11
        alloc0_vld = 1; alloc0_PR = 10; alloc1_vld = 1; alloc1_PR = 11;
        srcs(10, 11, 0, 0);
        ev[10] = 1'b0; ev[11] = 1'b0;
        commit(4'b1111, 7'd2);
        // S21: AGU/BRU bypass
        AGU_result_vld = 1; AGU_result_PR = 10; BRU_result_vld = 1; BRU_result_PR = 11;
        srcs(10, 11, 11, 10);
        ev[10] = 1'b1; ev[11] = 1'b1;
        commit(4'b1111, 7'd0);

        for (int i = 0; i < 5 && sbq.size() > 0; i++) @(negedge clk);
        #1;
        if (sbq.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expected entries left, required 0", sbq.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pr_busy_table.md
PR_BUSY_TABLE -- requirements
Module: pr_busy_table

Interface
REQ-001 SHALL have parameter NUM_PR, default 64, the number of physical registers.
REQ-002 SHALL have parameter PR_W, default 6, the physical-register index width.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all state updates on the posedge.
REQ-004 SHALL have port rst, input, 1 bit; reset is synchronous and active-high.
REQ-005 SHALL have ports alloc0_vld and alloc1_vld, input, 1 bit each, rename slot 0/1 destination allocation valid.
REQ-006 SHALL have ports alloc0_PR and alloc1_PR, input, PR_W bits each, the allocated destination PR.
REQ-007 SHALL have ports ALU0_result_vld, ALU1_result_vld, AGU_result_vld and BRU_result_vld, input, 1 bit each, writeback valid; these are the same signals that drive the register file write ports.
REQ-008 SHALL have ports ALU0_result_PR, ALU1_result_PR, AGU_result_PR and BRU_result_PR, input, PR_W bits each, the writeback destination PR.
REQ-009 SHALL have port flush, input, 1 bit, pipeline flush / mispredict recovery.
REQ-010 SHALL have ports src0_PR to src3_PR, input, PR_W bits each, source-operand queries: two sources for each of the two renamed instructions.
REQ-011 SHALL have ports src0_rdy to src3_rdy, output, 1 bit each, the ready status of the corresponding source operand.
REQ-012 SHALL have port ready_vec, output, NUM_PR bits, registered per-PR ready bits; 1 means the value is present in the register file.
REQ-013 SHALL have port busy_cnt, output, PR_W+1 bits, a registered count of zero bits in ready_vec.

Function
REQ-014 SHALL clear ready_vec[alloc_PR] to 0 at the next clock edge when allocN_vld is high and alloc_PR is not 0.
REQ-015 SHALL set ready_vec[PR] to 1 at the next clock edge for each writeback with vld high and PR not 0; all four writeback ports may be active in the same cycle.
REQ-016 SHALL hold ready_vec[0] at 1 at all times; allocations and writebacks to PR0 SHALL be ignored.
REQ-017 SHALL give allocation priority over writeback when both target the same PR in the same cycle, so the bit ends at 0.
REQ-018 SHALL clear the PR to 0 when both alloc slots name the same PR in the same cycle.
REQ-019 SHALL set every bit of ready_vec to 1 at the next edge when flush is high; flush SHALL override same-cycle allocations and writebacks.
REQ-020 SHALL drive srcN_rdy combinationally as ready_vec[srcN_PR] OR (any writeback this cycle with vld high and PR equal to srcN_PR), giving 0-cycle writeback bypass.
REQ-021 SHALL drive srcN_rdy to 1 when srcN_PR is 0.
REQ-022 SHALL NOT apply same-cycle allocations to srcN_rdy; intra-group dependencies are resolved by rename.
REQ-023 SHALL update busy_cnt in the same edge as ready_vec, so that busy_cnt always equals the number of 0 bits in the current ready_vec, with a range of 0 to NUM_PR-1.
REQ-024 SHALL treat duplicate writebacks to the same PR in one cycle as idempotent: one set, and busy_cnt decrements at most once.

Reset
REQ-025 SHALL, while rst is high at a clock edge, set ready_vec to all ones and busy_cnt to 0; rst SHALL override flush, allocations and writebacks.
REQ-026 SHALL drive srcN_rdy from the reset state of ready_vec in the cycle after reset.

Structure
REQ-027 SHALL take NUM_PR, PR_W and the writeback-port count of 4 from the shared core package used by the register file and rename.
REQ-028 SHALL implement each of the four bypass comparators in a sub-module pr_wb_match: inputs are a query PR plus the four writeback vld/PR pairs, output is a match bit.
REQ-029 SHALL compute busy_cnt from next-state ready_vec, either by popcount or by an incremental adjust with identical results.

Verification
REQ-030 SHALL cover this scenario: reset, then alloc0 PR5 and alloc1 PR9 -> next cycle ready_vec[5]=0, ready_vec[9]=0, busy_cnt=2.
REQ-031 SHALL cover this scenario: PR5 busy and ALU1 writeback to PR5 with src2_PR=5 in the same cycle -> src2_rdy=1 that cycle, ready_vec[5]=1 and busy_cnt=1 next cycle.
REQ-032 SHALL cover this scenario: alloc0 PR12 and AGU writeback PR12 in the same cycle -> ready_vec[12]=0 next cycle.
REQ-033 SHALL cover this scenario: alloc to PR0 and src0_PR=0 -> ready_vec[0]=1, src0_rdy=1, busy_cnt unchanged.
REQ-034 SHALL cover this scenario: 10 PRs busy, then flush plus a same-cycle alloc of PR20 -> next cycle ready_vec all ones, busy_cnt=0.
REQ-035 SHALL cover this scenario: all four writebacks to distinct busy PRs 3, 4, 7 and 8 in one cycle with busy_cnt=6 -> busy_cnt=2 next cycle; repeat with all four targeting PR3 -> busy_cnt decrements by 1.
